// File: rtl/match_pkg.sv
// Shared definitions for the match sequencer and its threshold comparator.
// THRESHOLD is the single reference value for both blocks.
package match_pkg;

  localparam int COUNT_W = 4;
  localparam logic [COUNT_W-1:0] THRESHOLD = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/match_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Count sequencer feeding the threshold comparator; freezes on a hit for a
// programmable dwell (or stops in one-shot mode) and records hits.
module match_sequencer
  import match_pkg::*;
#(
  parameter int HOLD_CYCLES = 3,
  parameter int HIT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               en,
  input  logic               one_shot,
  input  logic               match,
  input  logic               irq_ack,
  output logic [COUNT_W-1:0] count,
  output logic [1:0]         state_o,
  output logic               irq,
  output logic [HIT_W-1:0]   hit_cnt
);

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  state_t             state, state_n;
  logic [COUNT_W-1:0] count_n;
  logic [3:0]         hold, hold_n;
  logic               irq_n;
  logic               hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      hold  <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      hold  <= hold_n;
      irq   <= irq_n;
    end
  end

  // clear and stop pre-empt everything, including a hit in RUN
  assign hit = !clear && !stop && (state == RUN) && match;

  always_comb begin
    state_n = state;
    count_n = count;
    hold_n  = hold;
    irq_n   = irq;

    if (hit) begin
      irq_n = 1'b1;
    end else if (irq_ack) begin
      irq_n = 1'b0;
    end

    if (clear) begin
      state_n = IDLE;
      count_n = '0;
      hold_n  = '0;
      irq_n   = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            count_n = load_val;
          end else if (start) begin
            state_n = RUN;
          end
        end
        RUN: begin
          if (match) begin
            if (one_shot) begin
              state_n = DONE;
            end else begin
              state_n = HOLD;
              hold_n  = HOLD_INIT;
            end
          end else if (en) begin
            count_n = count + 1'b1;
          end
        end
        HOLD: begin
          // stepping past the threshold on exit keeps match from re-firing
          if (hold == 4'd0) begin
            count_n = count + 1'b1;
            state_n = RUN;
          end else begin
            hold_n = hold - 4'd1;
          end
        end
        DONE: begin
          if (start) begin
            state_n = RUN;
            count_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign state_o = state;

  sat_counter #(.W(HIT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .clr   (clear),
    .value (hit_cnt)
  );

endmodule
